// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end.
// Holds the datapath widths, the default reset PC and the fetch FSM state type.
package mips_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with word-aligned load and increment-by-4.
// A load takes priority over the increment.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc_en,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Wraps modulo 2^32 naturally.
    assign pc_plus4 = pc_q + ADDR_W'(4);
    assign pc       = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = load_val & ~ADDR_W'(3);
        end else if (inc_en) begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, memory request handshake and a one-entry output buffer
// toward decode with valid/ready flow control.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_REQ  | buffer empty, request outstanding at Imem_Addr = PC
//   S_HOLD | buffer full, next request issued only when decode consumes
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [ADDR_W-1:0]  Next_PC,
    input  logic               PC_Load,
    output logic [ADDR_W-1:0]  PC_Plus4,
    output logic               Imem_Req,
    output logic [ADDR_W-1:0]  Imem_Addr,
    input  logic               Imem_Ack,
    input  logic [INSTR_W-1:0] Imem_Data,
    output logic [INSTR_W-1:0] Instr,
    output logic [ADDR_W-1:0]  Instr_PC,
    output logic               Instr_Valid,
    input  logic               Instr_Ready
);

    fetch_state_t       state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  pc;
    logic               fetch;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (Clk),
        .rst      (Reset),
        .load_en  (PC_Load),
        .load_val (Next_PC),
        .inc_en   (fetch),
        .pc       (pc),
        .pc_plus4 (PC_Plus4)
    );

    assign Imem_Addr = pc;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (PC_Load) begin
            state_d = S_REQ;
        end else begin
            case (state_q)
                S_REQ:   if (Imem_Ack) state_d = S_HOLD;
                S_HOLD:  if (Instr_Ready && !Imem_Ack) state_d = S_REQ;
                default: state_d = S_REQ;
            endcase
        end
    end

    // Request in S_HOLD follows Instr_Ready combinationally for back-to-back fetch.
    always_comb begin
        Imem_Req = 1'b0;
        if (!Reset) begin
            Imem_Req = (state_q == S_REQ) || Instr_Ready;
        end
        fetch = Imem_Req && Imem_Ack && !PC_Load;
    end

    always_comb begin
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        if (PC_Load) begin
            valid_d = 1'b0;
        end else if (fetch) begin
            instr_d    = Imem_Data;
            instr_pc_d = pc;
            valid_d    = 1'b1;
        end else if (valid_q && Instr_Ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

    assign Instr       = instr_q;
    assign Instr_PC    = instr_pc_q;
    assign Instr_Valid = valid_q;

endmodule
